// File: rtl/eia232_tx_arbiter_if.sv
// Handshake bundle between the requesters, the transmit arbiter and the UART transmitter.
interface eia232_tx_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]      req;
  logic [32*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      grant;
  logic                 pause;
  logic                 send;
  logic [31:0]          wrdata;
  logic                 busy;
  logic                 active;
  logic                 timeout;

  modport master (
    output req, req_data, pause, busy,
    input  grant, send, wrdata, active, timeout
  );

  modport slave (
    input  req, req_data, pause, busy,
    output grant, send, wrdata, active, timeout
  );
endinterface

// File: rtl/eia232_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ word sources.
// Optional macro EIA232_ARB_PRIORITY_EN gives requester 0 strict priority.
module eia232_tx_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  eia232_tx_arbiter_if.slave    bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       wrdata_q, wrdata_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              send_q, send_d;
  logic              active_q, active_d;
  logic              timeout_q, timeout_d;

  logic              found;
  logic              upd_last;
  int unsigned       win;
  int unsigned       idx;

  // Scan starts one past the last winner so every pending requester is reached in turn.
  always_comb begin
    found    = 1'b0;
    upd_last = 1'b1;
    win      = 0;
    idx      = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
`ifdef EIA232_ARB_PRIORITY_EN
    // Requester 0 bypasses the rotation and leaves it untouched for the others.
    if (bus.req[0]) begin
      found    = 1'b1;
      win      = 0;
      upd_last = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    wrdata_d  = wrdata_q;
    grant_d   = '0;
    send_d    = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found && !bus.pause && !bus.busy) begin
          wrdata_d     = bus.req_data[32*win +: 32];
          grant_d[win] = 1'b1;
          if (upd_last) begin
            last_d = IW'(win);
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        send_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never acknowledged: drop the word rather than retry.
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!bus.busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      last_q    <= IW'(NREQ - 1);
      cnt_q     <= '0;
      wrdata_q  <= '0;
      grant_q   <= '0;
      send_q    <= 1'b0;
      active_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      wrdata_q  <= wrdata_d;
      grant_q   <= grant_d;
      send_q    <= send_d;
      active_q  <= active_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.send    = send_q;
  assign bus.wrdata  = wrdata_q;
  assign bus.active  = active_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_eia232_tx_arbiter.sv
// Scoreboard bench for eia232_tx_arbiter: expected grants are queued by the stimulus and checked by a monitor.
module tb_eia232_tx_arbiter;

  localparam int unsigned NREQ = 4;

  logic clk;
  logic rst;

  eia232_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  eia232_tx_arbiter #(
    .NREQ         (NREQ),
    .BUSY_TIMEOUT (15)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    int unsigned idx;
    logic [31:0] data;
  } exp_t;

  exp_t        gq[$];
  logic [31:0] sq[$];
  exp_t        mon_e;

  int total = 0;
  int bad   = 0;
  int grant_cnt = 0;
  int send_cnt  = 0;
  int to_cnt    = 0;

  logic [NREQ-1:0] req_r;
  logic [31:0]     d [NREQ];
  logic            pause_r;
  logic            force_busy;
  logic            tx_en;
  int unsigned     tx_len;
  int unsigned     tx_cnt;
  logic            mdl_busy;

  assign bus.req      = req_r;
  assign bus.req_data = {d[3], d[2], d[1], d[0]};
  assign bus.pause    = pause_r;
  assign mdl_busy     = (tx_cnt != 0);
  assign bus.busy     = mdl_busy | force_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: busy rises the cycle after send and lasts tx_len cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) tx_cnt <= 0;
    else if (bus.send && tx_en) tx_cnt <= tx_len;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.grant != '0) begin
        grant_cnt++;
        if (gq.size() == 0) begin
          check("unexpected_grant", 32'(bus.grant), 32'h0);
        end else begin
          mon_e = gq.pop_front();
          check("grant_vec", 32'(bus.grant), 32'd1 << mon_e.idx);
          sq.push_back(mon_e.data);
        end
      end
      if (bus.send) begin
        send_cnt++;
        check("send_while_busy", 32'(bus.busy), 32'h0);
        if (sq.size() == 0) check("unexpected_send", 32'h1, 32'h0);
        else check("wrdata", bus.wrdata, sq.pop_front());
      end
      if (bus.timeout) to_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    req_r      = '0;
    pause_r    = 1'b0;
    force_busy = 1'b0;
    rst        = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_grants(input int target, input int budget, input string nm);
    int n = 0;
    while (grant_cnt < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check(nm, 32'(grant_cnt >= target), 32'h1);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (bus.active && n < budget);
    check(nm, 32'(bus.active), 32'h0);
  endtask

  task automatic check_drained(input string nm);
    check(nm, 32'(gq.size() + sq.size()), 32'h0);
  endtask

  initial begin
    int gcyc, scyc, afall, sends, g0, s0, t0;
    int g1, g2, s1, t1;
    logic act_at_t, to_next;

    d[0] = 32'h1000_0000; d[1] = 32'h2111_1111; d[2] = 32'h3222_2222; d[3] = 32'h4333_3333;
    tx_en = 1'b1;
    tx_len = 40;
    do_reset();

    check("rst_grant",   32'(bus.grant),   32'h0);
    check("rst_send",    32'(bus.send),    32'h0);
    check("rst_wrdata",  bus.wrdata,       32'h0);
    check("rst_active",  32'(bus.active),  32'h0);
    check("rst_timeout", 32'(bus.timeout), 32'h0);

    // Single word with hand-counted latency.
    d[2] = 32'hDEADBEEF;
    gq.push_back('{2, 32'hDEADBEEF});
    req_r = 4'b0100;
    gcyc = -1; scyc = -1; afall = -1; sends = 0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(negedge clk);
      if (bus.grant != '0 && gcyc < 0) begin gcyc = cyc; req_r = '0; end
      if (bus.send) begin sends++; if (scyc < 0) scyc = cyc; end
      if (!bus.active && afall < 0 && cyc > 2) afall = cyc;
    end
    check("single_grant_cycle",  32'(gcyc),  32'd1);
    check("single_send_cycle",   32'(scyc),  32'd2);
    check("single_active_fall",  32'(afall), 32'd44);
    check("single_send_count",   32'(sends), 32'd1);
    check_drained("single_drained");

    // Fairness with all requesters pending.
    do_reset();
    d[2] = 32'h3222_2222;
    tx_len = 3;
`ifdef EIA232_ARB_PRIORITY_EN
    for (int i = 0; i < 6; i++) gq.push_back('{0, d[0]});
`else
    gq.push_back('{0, d[0]}); gq.push_back('{1, d[1]}); gq.push_back('{2, d[2]});
    gq.push_back('{3, d[3]}); gq.push_back('{0, d[0]}); gq.push_back('{1, d[1]});
`endif
    g0 = grant_cnt;
    req_r = 4'b1111;
    wait_grants(g0 + 6, 400, "fair_six_grants");
    req_r = '0;
    wait_idle(100, "fair_idle");
    check_drained("fair_drained");

    // Flow control.
    do_reset();
    tx_len = 40;
    pause_r = 1'b1;
    req_r = 4'b0010;
    g0 = grant_cnt;
    repeat (100) @(negedge clk);
    check("pause_holds_grant", 32'(grant_cnt - g0), 32'h0);
    gq.push_back('{1, d[1]});
    pause_r = 1'b0;
    @(negedge clk);
    check("pause_release_grant", 32'(bus.grant), 32'b0010);
    req_r = '0;
    for (int i = 0; i < 20 && !mdl_busy; i++) @(negedge clk);
    @(negedge clk);
    s0 = send_cnt;
    g0 = grant_cnt;
    pause_r = 1'b1;
    req_r = 4'b0001;
    wait_idle(60, "pause_word_completes");
    repeat (30) @(negedge clk);
    check("pause_blocks_next", 32'(grant_cnt - g0), 32'h0);
    check("pause_no_extra_send", 32'(send_cnt - s0), 32'h0);
    gq.push_back('{0, d[0]});
    pause_r = 1'b0;
    wait_grants(g0 + 1, 5, "pause_resume_grant");
    req_r = '0;
    wait_idle(60, "pause_idle");
    check_drained("pause_drained");

    // Busy timeout: the transmitter never answers.
    do_reset();
    tx_en = 1'b0;
    t0 = to_cnt;
    gq.push_back('{0, d[0]});
    gq.push_back('{0, d[0]});
    req_r = 4'b0001;
    g1 = -1; g2 = -1; s1 = -1; t1 = -1; act_at_t = 1'b1; to_next = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (bus.grant != '0) begin
        if (g1 < 0) g1 = cyc;
        else if (g2 < 0) begin g2 = cyc; req_r = '0; end
      end
      if (bus.send && s1 < 0) s1 = cyc;
      if (t1 >= 0 && cyc == t1 + 1) to_next = bus.timeout;
      if (bus.timeout && t1 < 0) begin t1 = cyc; act_at_t = bus.active; end
    end
    check("to_grant_cycle",   32'(g1), 32'd1);
    check("to_send_cycle",    32'(s1), 32'd2);
    check("to_pulse_cycle",   32'(t1), 32'd17);
    check("to_active_low",    32'(act_at_t), 32'h0);
    check("to_single_pulse",  32'(to_next), 32'h0);
    check("to_next_grant",    32'(g2), 32'd18);
    wait_idle(40, "to_idle");
    check("to_count", 32'(to_cnt - t0), 32'd2);
    check_drained("to_drained");
    tx_en = 1'b1;

    // Withdrawal while the transmitter is busy.
    do_reset();
    g0 = grant_cnt;
    s0 = send_cnt;
    force_busy = 1'b1;
    @(negedge clk);
    req_r = 4'b1000;
    @(negedge clk);
    req_r = '0;
    repeat (5) @(negedge clk);
    force_busy = 1'b0;
    repeat (20) @(negedge clk);
    check("withdraw_no_grant", 32'(grant_cnt - g0), 32'h0);
    check("withdraw_no_send",  32'(send_cnt - s0),  32'h0);
    check("withdraw_idle",     32'(bus.active),     32'h0);

    // Reset in the middle of a transfer.
    do_reset();
    tx_len = 40;
    g0 = grant_cnt;
    gq.push_back('{2, d[2]});
    req_r = 4'b0100;
    wait_grants(g0 + 1, 5, "mid_first_grant");
    req_r = '0;
    for (int i = 0; i < 20 && !mdl_busy; i++) @(negedge clk);
    @(negedge clk);
    check("mid_active_before", 32'(bus.active), 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_send",   32'(bus.send),   32'h0);
    check("mid_rst_grant",  32'(bus.grant),  32'h0);
    check("mid_rst_active", 32'(bus.active), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    g0 = grant_cnt;
    gq.push_back('{0, d[0]});
    gq.push_back('{3, d[3]});
    req_r = 4'b1001;
    wait_grants(g0 + 1, 5, "mid_post_grant0");
    req_r[0] = 1'b0;
    wait_grants(g0 + 2, 100, "mid_post_grant3");
    req_r = '0;
    wait_idle(60, "mid_idle");
    check_drained("mid_drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eia232_tx_arbiter.md
Name: eia232_tx_arbiter

Overview:
- Shares the single UART transmitter (send/wrdata/busy handshake) among NREQ requesters: sample readout, metadata dump, status/ID responder.
- Picks one pending 32-bit word per transfer using round-robin arbitration.
- Issues a one-cycle send pulse, then tracks the transmitter busy window until the word is fully shifted out.
- Holds off new transfers while flow control (XOFF) is asserted.

Parameters:
- NREQ, 4, number of requesters (2..8).
- BUSY_TIMEOUT, 15, cycles to wait for busy to rise after send before abandoning the transfer (4-bit counter sufficient; width = clog2(BUSY_TIMEOUT+1)).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NREQ  requester i has a word pending; held high with stable data until granted
- req_data  in  32*NREQ  word of requester i at bits [32i+31:32i]
- grant  out  NREQ  one-hot, single-cycle; word of that requester captured this cycle
- pause  in  1  flow-control hold (XOFF state); blocks new grants only
- send  out  1  one-cycle pulse to transmitter
- wrdata  out  32  registered word for transmitter, stable from send until return to IDLE
- busy  in  1  transmitter busy
- active  out  1  high in every state except IDLE
- timeout  out  1  one-cycle pulse when a transfer is abandoned

Behaviour:
- Reset (async): state=IDLE; send=0; grant=0; wrdata=0; active=0; timeout=0; last=NREQ-1 (so requester 0 wins first); counter=0.
- All outputs are registered.
- IDLE: a grant requires (req != 0) && !pause && !busy.
  - Winner = first set req bit scanning last+1, last+2, ... modulo NREQ.
  - Same edge: wrdata <= req_data[winner]; grant[winner]=1 for the following cycle; last <= winner; go ISSUE.
- ISSUE (1 cycle): send=1; counter cleared; go WAIT_BUSY.
  - Latency: req rising in IDLE -> grant high 1 cycle later -> send high 2 cycles later.
- WAIT_BUSY:
  - busy=1 -> WAIT_DONE.
  - Otherwise counter increments; when counter reaches BUSY_TIMEOUT, pulse timeout and go IDLE.
  - The word is dropped; no retry.
- WAIT_DONE: stays while busy=1; busy=0 -> IDLE. Next grant is earliest the cycle after IDLE is re-entered.
- pause rising during ISSUE, WAIT_BUSY or WAIT_DONE does not abort the current word; it only blocks the next grant.
- req dropping before grant is a legal withdrawal: no grant, no send.
- req dropping on the grant cycle: the captured word is still sent.
- Only one word in flight at a time; send never pulses while busy=1 or outside ISSUE.
- Round-robin wrap: last=NREQ-1 wraps the scan to 0.
- A single requester that is continuously pending is granted on every transfer.
- Reset asserted mid-transfer: send and grant drop immediately; the word is lost; the transmitter is reset independently.

Optional Feature:
- Macro EIA232_ARB_PRIORITY_EN.
- Defined: requester 0 (ID/status responder) has strict priority. If req[0] is set in IDLE it wins regardless of last; last is not updated by a requester-0 win, so round-robin order among 1..NREQ-1 is preserved.
- Not defined: pure round-robin across all NREQ requesters as above.

Test Plan:
- Single word: NREQ=4, req=4'b0100, req_data[2]=32'hDEADBEEF, busy rises 1 cycle after send and lasts 40 cycles -> grant=4'b0100 at cycle 1, send at cycle 2 with wrdata=DEADBEEF, active low at cycle 44, exactly one send.
- Fairness: req=4'b1111 held, each requester re-asserting after its grant -> grant order 0,1,2,3,0,1 without macro; with EIA232_ARB_PRIORITY_EN and req[0] always pending -> grants to 0 on every transfer.
- Flow control: pause=1 with req=4'b0010 -> no grant for 100 cycles; pause=0 -> grant within 1 cycle; pause raised in WAIT_DONE -> current word completes, next grant blocked.
- Timeout: busy tied 0, req=4'b0001 -> send pulse, then timeout pulse exactly BUSY_TIMEOUT=15 cycles after entering WAIT_BUSY, return to IDLE, next grant follows.
- Withdrawal and busy gate: req[3] pulsed 1 cycle while external busy=1 -> no grant, no send.
- Reset mid-operation: reset during WAIT_DONE -> send, grant and active 0 immediately; after release, req=4'b0001 granted first.
